// File: rtl/led_status_ctrl.sv
// led_status_ctrl: front-panel button LED and dual RGB indicator driver keyed off the one-hot vending FSM state.
module led_status_ctrl #(
  parameter int LED_W   = 16,
  parameter int CNT_MAX = 49_999_999,
  parameter int CNT_W   = 26
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [5:0]       state,
  input  logic [2:0]       in_goods_high,
  input  logic [2:0]       in_goods_low,
  input  logic [1:0]       in_goods_num,
  input  logic             chase_dir,
  output logic             tick,
  output logic [LED_W-1:0] led_btn,
  output logic             rgb1_r,
  output logic             rgb1_g,
  output logic             rgb1_b,
  output logic             rgb2_r,
  output logic             rgb2_g,
  output logic             rgb2_b
);
  localparam int FW = $clog2(LED_W + 1);
  localparam logic [5:0] IDLE      = 6'h01;
  localparam logic [5:0] GOODS_ONE = 6'h02;
  localparam logic [5:0] GOODS_TWO = 6'h04;
  localparam logic [5:0] PAYMENT   = 6'h08;
  localparam logic [5:0] CHANGE    = 6'h10;
  localparam logic [5:0] TEMP      = 6'h20;

  logic [CNT_W-1:0] cnt;
  logic             blink;
  logic [LED_W-1:0] chase;
  logic [LED_W-1:0] chase_init;
  logic [LED_W-1:0] led_nxt;
  logic [LED_W:0]   therm;
  logic [FW-1:0]    fill;
  logic [5:0]       prev_state;
  logic             entry;
  logic [2:0]       rgb1_nxt;
  logic [2:0]       rgb2_nxt;

  assign chase_init = chase_dir ? {1'b1, {(LED_W-1){1'b0}}} : {{(LED_W-1){1'b0}}, 1'b1};
  assign entry      = state != prev_state;
  // One bit wider so that fill == LED_W yields an all-ones bar.
  assign therm      = ({{LED_W{1'b0}}, 1'b1} << fill) - 1'b1;

  always_comb begin
    led_nxt  = '0;
    rgb1_nxt = 3'b000;
    rgb2_nxt = 3'b000;
    case (state)
      IDLE: led_nxt = chase;
      GOODS_ONE: begin
        led_nxt  = LED_W'({in_goods_num, in_goods_high, in_goods_low});
        rgb1_nxt = 3'b100;
      end
      GOODS_TWO: begin
        led_nxt  = LED_W'({in_goods_num, in_goods_high, in_goods_low});
        rgb1_nxt = 3'b010;
      end
      PAYMENT: begin
        led_nxt  = {LED_W{blink}};
        rgb1_nxt = 3'b001;
        rgb2_nxt = {2'b00, blink};
      end
      CHANGE: begin
        led_nxt  = '1;
        rgb1_nxt = 3'b110;
        rgb2_nxt = 3'b010;
      end
      TEMP: begin
        led_nxt  = therm[LED_W-1:0];
        rgb1_nxt = 3'b011;
        rgb2_nxt = {blink, 2'b00};
      end
      default: led_nxt = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt                      <= '0;
      tick                     <= 1'b0;
      blink                    <= 1'b0;
      chase                    <= chase_init;
      fill                     <= '0;
      prev_state               <= IDLE;
      led_btn                  <= '0;
      {rgb1_r, rgb1_g, rgb1_b} <= 3'b000;
      {rgb2_r, rgb2_g, rgb2_b} <= 3'b000;
    end else begin
      cnt        <= (cnt == CNT_W'(CNT_MAX)) ? '0 : cnt + 1'b1;
      // Registered so that tick is high while cnt sits at CNT_MAX.
      tick       <= cnt == CNT_W'(CNT_MAX - 1);
      blink      <= blink ^ tick;
      prev_state <= state;
      if (state == IDLE && entry)
        chase <= chase_init;
      else if (state == IDLE && tick)
        chase <= chase_dir ? {chase[0], chase[LED_W-1:1]} : {chase[LED_W-2:0], chase[LED_W-1]};
      if (state == TEMP && entry)
        fill <= '0;
      else if (state == TEMP && tick)
        fill <= (fill == FW'(LED_W)) ? '0 : fill + 1'b1;
      led_btn                  <= led_nxt;
      {rgb1_r, rgb1_g, rgb1_b} <= rgb1_nxt;
      {rgb2_r, rgb2_g, rgb2_b} <= rgb2_nxt;
    end
  end
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: directed vectors for led_status_ctrl with a 4-clock tick.
module tb_led_status_ctrl;
  localparam int LW = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [5:0]    state = 6'h01;
  logic [2:0]    in_goods_high = '0;
  logic [2:0]    in_goods_low = '0;
  logic [1:0]    in_goods_num = '0;
  logic          chase_dir = 1'b0;
  logic          tick;
  logic [LW-1:0] led_btn;
  logic          rgb1_r, rgb1_g, rgb1_b, rgb2_r, rgb2_g, rgb2_b;
  logic [2:0]    rgb1, rgb2;
  logic          mb;
  int            n_vec = 0;
  int            n_bad = 0;

  assign rgb1 = {rgb1_r, rgb1_g, rgb1_b};
  assign rgb2 = {rgb2_r, rgb2_g, rgb2_b};

  always #5 clk = ~clk;

  led_status_ctrl #(.LED_W(LW), .CNT_MAX(3), .CNT_W(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .state(state),
    .in_goods_high(in_goods_high), .in_goods_low(in_goods_low), .in_goods_num(in_goods_num),
    .chase_dir(chase_dir), .tick(tick), .led_btn(led_btn),
    .rgb1_r(rgb1_r), .rgb1_g(rgb1_g), .rgb1_b(rgb1_b),
    .rgb2_r(rgb2_r), .rgb2_g(rgb2_g), .rgb2_b(rgb2_b)
  );

  // Expected blink phase: starts low, flips on every tick.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mb <= 1'b0;
    else if (tick) mb <= ~mb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    if (!tick) chk("tick_timeout", {31'd0, tick}, 32'd1);
  endtask

  task automatic step();
    int n;
    wait_tick(n);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input logic dir);
    chase_dir = dir;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_led", 32'(led_btn), 32'h0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_rgb", {26'd0, rgb1, rgb2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("chase_start", 32'(led_btn), 32'h0001);
    chk("idle_rgb", {26'd0, rgb1, rgb2}, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("chase_up%0d", i), 32'(led_btn), (32'h1 << (i % 16)));
    end

    do_reset(1'b1);
    chk("chase_dn_start", 32'(led_btn), 32'h8000);
    step();
    chk("chase_dn1", 32'(led_btn), 32'h4000);
    chase_dir = 1'b0;
    step();
    chk("chase_dir_flip", 32'(led_btn), 32'h8000);

    state = 6'h02;
    in_goods_num = 2'b10;
    in_goods_high = 3'b101;
    in_goods_low = 3'b011;
    @(negedge clk);
    chk("goods1_led", 32'(led_btn), 32'h00AB);
    chk("goods1_rgb1", 32'(rgb1), 32'h4);
    chk("goods1_rgb2", 32'(rgb2), 32'h0);
    state = 6'h04;
    @(negedge clk);
    chk("goods2_rgb1", 32'(rgb1), 32'h2);
    chk("goods2_led", 32'(led_btn), 32'h00AB);

    state = 6'h08;
    @(negedge clk);
    chk("pay_rgb1", 32'(rgb1), 32'h1);
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      if (k > 0) chk("tick_gap", 32'(n), 32'd2);
      @(negedge clk);
      chk("tick_width", {31'd0, tick}, 32'd0);
      @(negedge clk);
      chk($sformatf("pay_led%0d", k), 32'(led_btn), mb ? 32'hFFFF : 32'h0);
      chk($sformatf("pay_rgb2_%0d", k), 32'(rgb2), {31'd0, mb});
    end

    wait_tick(n);
    state = 6'h20;
    repeat (2) @(negedge clk);
    chk("temp_entry_led", 32'(led_btn), 32'h0);
    chk("temp_rgb1", 32'(rgb1), 32'h3);
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("temp_fill%0d", i), 32'(led_btn), (i == 17) ? 32'h0 : ((32'h1 << i) - 32'h1));
      if (i == 1) chk("temp_rgb2", 32'(rgb2), {29'd0, mb, 2'b00});
    end

    state = 6'h10;
    repeat (2) @(negedge clk);
    chk("change_led", 32'(led_btn), 32'hFFFF);
    chk("change_rgb", {26'd0, rgb1, rgb2}, 32'h32);

    state = 6'h03;
    repeat (2) @(negedge clk);
    chk("illegal_led", 32'(led_btn), 32'h0);
    chk("illegal_rgb", {26'd0, rgb1, rgb2}, 32'h0);

    state = 6'h01;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) step();
    chk("idle_0100", 32'(led_btn), 32'h0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led_btn), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_led", 32'(led_btn), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
